// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone command initiator: state encoding,
// timeout counter sizing and the data value returned on failed transfers.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    // A TIMEOUT of 0 still needs a 1-bit counter so the port widths stay legal.
    function automatic int unsigned wb_tmo_w(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 1);
        return (w == 0) ? 1 : w;
    endfunction

    localparam logic WB_ERR_DAT_BIT = 1'b0;

endpackage

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic single-transfer master: one bus cycle per command on the
// valid/ready command port, result returned on the valid/ready response port.
module wb_cmd_initiator
    import wb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            rsp_tmo,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    output logic [DW/8-1:0] wbm_sel_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i,
    output logic            busy
);

    // state   | meaning
    // IDLE    | waiting for a command; cmd_ready high
    // BUS     | cyc/stb asserted, waiting for ack, err or timeout
    // RESP    | response held on the rsp port until rsp_ready

    localparam int TMO_W = wb_tmo_w(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [DW-1:0] ERR_DAT = {DW{WB_ERR_DAT_BIT}};

    wb_state_e          state_q, state_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [AW-1:0]      adr_q, adr_d;
    logic [DW-1:0]      dat_q, dat_d;
    logic [DW/8-1:0]    sel_q, sel_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]      rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_tmo_q, rsp_tmo_d;
    logic               busy_q, busy_d;
    logic               tmo_hit;

    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        rsp_tmo_d   = rsp_tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                if (cnt_q != {TMO_W{1'b1}}) begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
                // ack takes priority over a simultaneous err
                if (wbm_ack_i) begin
                    rsp_dat_d   = we_q ? ERR_DAT : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_tmo_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    state_d     = ST_RESP;
                end else if (wbm_err_i) begin
                    rsp_dat_d   = ERR_DAT;
                    rsp_err_d   = 1'b1;
                    rsp_tmo_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    state_d     = ST_RESP;
                end else if (tmo_hit) begin
                    rsp_dat_d   = ERR_DAT;
                    rsp_err_d   = 1'b1;
                    rsp_tmo_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_tmo_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_tmo   = rsp_tmo_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Self-checking bench for wb_cmd_initiator: scripted slave responses, with
// expected responses queued at command time and popped at the rsp handshake.
module tb_wb_cmd_initiator;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 4;

    localparam int M_ACK    = 0;
    localparam int M_ERR    = 1;
    localparam int M_BOTH   = 2;
    localparam int M_SILENT = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_tmo;
    logic [DW-1:0] rsp_dat;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic [SW-1:0] wbm_sel_o;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_ack_i, wbm_err_i;
    logic          busy;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          err;
        logic          tmo;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    wb_cmd_initiator #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .rsp_tmo   (rsp_tmo),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Entered and left on a negedge. The slave answers on the stb cycle
    // numbered 'delay' (0 = first). 'hold' keeps rsp_ready low that many
    // cycles with cmd_valid raised, and leaves cmd_valid high on return.
    task automatic do_cmd(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input logic [SW-1:0] sel, input int mode, input int delay,
                          input logic [DW-1:0] rdata, input int exp_cyc, input int hold);
        rsp_t e;
        rsp_t got;
        rsp_t snap;
        int   n;
        e.dat = ((mode == M_ACK || mode == M_BOTH) && !we) ? rdata : '0;
        e.err = (mode == M_ERR || mode == M_SILENT);
        e.tmo = (mode == M_SILENT);
        exp_q.push_back(e);

        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        check_eq("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;

        n = 0;
        while (wbm_cyc_o === 1'b1 && n < 50) begin
            check_eq("stb", wbm_stb_o, 1);
            check_eq("we", wbm_we_o, we);
            check_eq("adr", wbm_adr_o, adr);
            check_eq("sel", wbm_sel_o, sel);
            if (we) check_eq("wdat", wbm_dat_o, dat);
            check_eq("cmd_ready_bus", cmd_ready, 0);
            check_eq("busy_bus", busy, 1);
            if (mode != M_SILENT && n == delay) begin
                wbm_dat_i = rdata;
                wbm_ack_i = (mode == M_ACK || mode == M_BOTH);
                wbm_err_i = (mode == M_ERR || mode == M_BOTH);
            end
            n++;
            @(negedge clk);
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            wbm_dat_i = 32'hBAD0_BAD0;
        end
        check_eq("cyc_len", n, exp_cyc);
        check_eq("rsp_valid_m1", rsp_valid, 1);
        check_eq("stb_low", wbm_stb_o, 0);
        snap = {rsp_dat, rsp_err, rsp_tmo};

        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            check_eq("bp_cmd_ready", cmd_ready, 0);
            check_eq("bp_no_cyc", wbm_cyc_o, 0);
            check_eq("bp_rsp_valid", rsp_valid, 1);
            got = {rsp_dat, rsp_err, rsp_tmo};
            check_eq("bp_rsp_stable", got, snap);
            @(negedge clk);
        end

        rsp_ready = 1'b1;
        check_eq("rsp_valid_hs", rsp_valid, 1);
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check_eq("rsp_dat", rsp_dat, e.dat);
            check_eq("rsp_err", rsp_err, e.err);
            check_eq("rsp_tmo", rsp_tmo, e.tmo);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = (hold > 0);
        check_eq("rsp_drop", rsp_valid, 0);
        check_eq("err_clear", rsp_err, 0);
        check_eq("ready_after_hs", cmd_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        wbm_dat_i = '0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_cyc", wbm_cyc_o, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rsp_dat", rsp_dat, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // write, ack on third stb cycle
        do_cmd(1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF, M_ACK, 2, 32'hFFFF_FFFF, 3, 0);
        // read, ack on first stb cycle
        do_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF, M_ACK, 0, 32'h1234_5678, 1, 0);
        // silent slave -> timeout after exactly TMO cycles
        do_cmd(1'b0, 32'h3000_000C, 32'h0, 4'hF, M_SILENT, 0, 32'h5555_5555, 4, 0);
        // ack and err together: ack wins
        do_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, M_BOTH, 1, 32'hCAFE_F00D, 2, 0);
        // err alone
        do_cmd(1'b0, 32'h3000_0014, 32'h0, 4'h3, M_ERR, 0, 32'h7777_7777, 1, 0);
        // backpressure, then next command accepted immediately
        do_cmd(1'b0, 32'h3000_0018, 32'h0, 4'hF, M_ACK, 1, 32'hDEAD_BEEF, 2, 5);
        do_cmd(1'b1, 32'h3000_001C, 32'h0BAD_CAFE, 4'h3, M_ACK, 0, 32'h0, 1, 0);

        // stray ack/err while idle must not produce a response
        wbm_ack_i = 1'b1;
        wbm_err_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        @(negedge clk);
        check_eq("idle_ack_rsp", rsp_valid, 0);
        check_eq("idle_ack_busy", busy, 0);

        // reset in the middle of a bus cycle
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0020;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("pre_rst_cyc", wbm_cyc_o, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_cyc", wbm_cyc_o, 0);
        check_eq("async_rst_stb", wbm_stb_o, 0);
        check_eq("async_rst_rsp", rsp_valid, 0);
        check_eq("async_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", cmd_ready, 1);
        check_eq("post_rst_cyc", wbm_cyc_o, 0);
        check_eq("post_rst_busy", busy, 0);

        check_eq("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
